// File: rtl/iter_divider.sv
// ---------------------------------------------------------------------------
// iter_divider
//   Multi-cycle RV32M divide/remainder unit. It produces one quotient bit per
//   clock by restoring subtraction on operand magnitudes, then applies the
//   RISC-V sign rules. The b==0 and signed-overflow cases skip the iteration
//   and finish after one clock.
//
// Ports
//   clk      in   1     system clock, rising edge
//   reset_n  in   1     asynchronous active-low reset
//   start    in   1     request, sampled only in IDLE
//   op       in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU (sampled with start)
//   a        in   XLEN  dividend (sampled with start)
//   b        in   XLEN  divisor  (sampled with start)
//   flush    in   1     synchronous cancel of an in-flight operation
//   busy     out  1     high whenever the FSM is not in IDLE
//   done     out  1     one-cycle pulse, y valid in that cycle
//   y        out  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands are captured here
// RUN   | one restoring step per clock, count runs XLEN down to 1
// DONE  | y is valid, done pulses for one cycle, then back to IDLE
// ---------------------------------------------------------------------------
module iter_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] y
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_nx;
    logic [XLEN-1:0] rem_q, rem_nx;
    logic [XLEN-1:0] quo_q, quo_nx;
    logic [XLEN-1:0] dvsr_q, dvsr_nx;
    logic [CW-1:0]   count_q, count_nx;
    logic            neg_quo_q, neg_quo_nx;
    logic            neg_rem_q, neg_rem_nx;
    logic            is_rem_q, is_rem_nx;
    logic [XLEN-1:0] y_q, y_nx;

    // Operand decode at start
    logic            signed_op;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            b_zero;
    logic            ovf;
    logic [XLEN-1:0] special_y;

    // One restoring step
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            take;
    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] fix_quo;
    logic [XLEN-1:0] fix_rem;
    logic            last_step;

    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & a[XLEN-1];
        b_neg     = signed_op & b[XLEN-1];
        a_abs     = a_neg ? (~a + 1'b1) : a;
        b_abs     = b_neg ? (~b + 1'b1) : b;
        b_zero    = (b == '0);
        ovf       = signed_op && (a == INT_MIN) && (b == '1);

        if (b_zero) begin
            special_y = op[1] ? a : '1;
        end else begin
            special_y = op[1] ? '0 : INT_MIN;
        end
    end

    // The dividend bits enter the remainder from the top of quo, so the
    // quotient register doubles as the dividend shift register. The compare
    // is done one bit wider than XLEN so the borrow decides the quotient bit.
    always_comb begin
        shifted   = {rem_q, quo_q[XLEN-1]};
        diff      = shifted - {1'b0, dvsr_q};
        take      = ~diff[XLEN];
        step_rem  = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        step_quo  = {quo_q[XLEN-2:0], take};
        fix_quo   = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
        fix_rem   = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
        last_step = (count_q == CW'(1));
    end

    always_comb begin
        state_nx   = state_q;
        rem_nx     = rem_q;
        quo_nx     = quo_q;
        dvsr_nx    = dvsr_q;
        count_nx   = count_q;
        neg_quo_nx = neg_quo_q;
        neg_rem_nx = neg_rem_q;
        is_rem_nx  = is_rem_q;
        y_nx       = y_q;
        busy       = (state_q != IDLE);
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    if (b_zero || ovf) begin
                        y_nx     = special_y;
                        state_nx = DONE;
                    end else begin
                        rem_nx     = '0;
                        quo_nx     = a_abs;
                        dvsr_nx    = b_abs;
                        count_nx   = CW'(XLEN);
                        neg_quo_nx = a_neg ^ b_neg;
                        neg_rem_nx = a_neg;
                        is_rem_nx  = op[1];
                        state_nx   = RUN;
                    end
                end
            end

            RUN: begin
                if (flush) begin
                    state_nx = IDLE;
                end else begin
                    rem_nx   = step_rem;
                    quo_nx   = step_quo;
                    count_nx = count_q - CW'(1);
                    if (last_step) begin
                        y_nx     = is_rem_q ? fix_rem : fix_quo;
                        state_nx = DONE;
                    end
                end
            end

            DONE: begin
                done     = ~flush;
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            count_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
            y_q       <= '0;
        end else begin
            state_q   <= state_nx;
            rem_q     <= rem_nx;
            quo_q     <= quo_nx;
            dvsr_q    <= dvsr_nx;
            count_q   <= count_nx;
            neg_quo_q <= neg_quo_nx;
            neg_rem_q <= neg_rem_nx;
            is_rem_q  <= is_rem_nx;
            y_q       <= y_nx;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_iter_divider.sv
// ---------------------------------------------------------------------------
// tb_iter_divider
//   Scoreboard bench for iter_divider. The driver pushes the expected result
//   and the expected done cycle for every accepted request; a monitor pops
//   and compares on each done pulse.
// ---------------------------------------------------------------------------
module tb_iter_divider;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] y;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef struct {
        logic [31:0] y;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] held_y = 32'h0;

    iter_divider #(.XLEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .y       (y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // RISC-V division semantics via 64-bit arithmetic (truncating division,
    // remainder takes the dividend's sign; -2^31/-1 falls out naturally).
    function automatic logic [31:0] model_y(input logic [1:0] o, input logic [31:0] aa,
                                            input logic [31:0] bb);
        longint sa, sb_, q, r;
        if (bb == 32'h0) return o[1] ? aa : 32'hFFFF_FFFF;
        if (!o[0]) begin
            sa  = longint'($signed(aa));
            sb_ = longint'($signed(bb));
        end else begin
            sa  = longint'(aa);
            sb_ = longint'(bb);
        end
        q = sa / sb_;
        r = sa % sb_;
        return o[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] aa,
                                     input logic [31:0] bb);
        if (bb == 32'h0) return 1;
        if (!o[0] && aa == 32'h8000_0000 && bb == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", {31'b0, busy}, 32'h0);
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         input string nm);
        exp_t e;
        wait_idle();
        op    = o;
        a     = aa;
        b     = bb;
        start = 1'b1;
        e.y    = model_y(o, aa, bb);
        e.cyc  = cyc + model_lat(o, aa, bb);
        e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // A start that is not expected to produce a checked result
    task automatic raw_start(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb);
        op    = o;
        a     = aa;
        b     = bb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", y, held_y);
                chk("unexpected_done_pulse", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_y"}, y, e.y);
                chk({e.name, "_latency"}, cyc, e.cyc);
                held_y = e.y;
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        op      = 2'b00;
        a       = 32'h0;
        b       = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_y", y, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        issue(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
        issue(OP_REMU, 32'd100, 32'd7, "remu_100_7");
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        issue(OP_REM, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        issue(OP_DIVU, 32'd5, 32'd0, "divu_5_0");
        issue(OP_REM, 32'd5, 32'd0, "rem_5_0");
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
        issue(OP_REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, "rem_m7_m2");
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
        issue(OP_REMU, 32'd3, 32'hFFFF_FFFF, "remu_small_big");
        wait_idle();
        @(negedge clk);

        // Flush during RUN: no done, busy drops, y keeps its old value
        raw_start(OP_DIVU, 32'd1234567, 32'd89);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_run_busy", {31'b0, busy}, 32'h0);
        chk("flush_run_y_held", y, held_y);
        issue(OP_DIVU, 32'd9, 32'd3, "divu_after_flush");
        wait_idle();

        // Flush while in DONE suppresses the pulse
        op = OP_DIVU; a = 32'd77; b = 32'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_done_pulse", {31'b0, done}, 32'h0);
        @(posedge clk);
        #1 flush = 1'b0;
        held_y = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("flush_done_busy", {31'b0, busy}, 32'h0);

        // Flush in IDLE drops a start
        op = OP_DIVU; a = 32'd50; b = 32'd5; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_idle_busy", {31'b0, busy}, 32'h0);

        // Second start while busy is ignored
        issue(OP_DIVU, 32'd1000, 32'd10, "divu_first");
        repeat (5) @(negedge clk);
        chk("second_start_busy", {31'b0, busy}, 32'h1);
        raw_start(OP_REMU, 32'd999, 32'd0);
        wait_idle();

        // Start held into DONE is ignored
        issue(OP_DIVU, 32'd42, 32'd0, "divu_special_hold");
        op = OP_REMU; a = 32'd11; b = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);

        // Reset during RUN aborts asynchronously
        raw_start(OP_DIVU, 32'd500, 32'd3);
        repeat (15) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_run_busy", {31'b0, busy}, 32'h0);
        chk("rst_run_done", {31'b0, done}, 32'h0);
        chk("rst_run_y", y, 32'h0);
        held_y = 32'h0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        issue(OP_REMU, 32'd500, 32'd3, "remu_after_reset");

        // Randomized traffic, biased toward the special cases
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            int          sel;
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'h0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 16));
            else if (sel == 3) rb = rb | 32'h8000_0000;
            issue(ro, ra, rb, $sformatf("rand%0d", i));
        end

        begin
            int n = 0;
            while (sb.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        chk("scoreboard_empty", sb.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
